// File: rtl/pipe_reg_skid_pkg.sv
// Shared types for the skid-buffered pipeline register.
package pipe_pkg;

  // Occupancy state; the encoding doubles as the entry count.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } skid_state_t;

  // Width of the occupancy count output (0..2).
  localparam int COUNT_W = 2;

endpackage

// File: rtl/pipe_reg_skid_en_reg.sv
// Enabled data register with synchronous reset and clear, both loading RESET_VALUE.
module en_reg #(
  parameter int                WIDTH       = 32,
  parameter logic [WIDTH-1:0]  RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Reset and clear take priority over a load; otherwise hold.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_q <= RESET_VALUE;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_reg_skid.sv
// Pipeline register with valid/ready handshake, one-entry skid buffer,
// synchronous flush and a saturating back-pressure counter.
module pipe_reg_skid
  import pipe_pkg::*;
#(
  parameter int                WIDTH       = 32,
  parameter logic [WIDTH-1:0]  RESET_VALUE = {WIDTH{1'b0}},
  parameter int                CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [COUNT_W-1:0] count,
  output logic [CNT_W-1:0]   stall_cnt
);

  skid_state_t      r_state;
  logic [CNT_W-1:0] r_stallCnt;

  logic             w_inReady;
  logic             w_outValid;
  logic             w_inXfer;
  logic             w_outXfer;
  logic             w_stall;
  logic             w_mainEn;
  logic             w_skidEn;
  logic [WIDTH-1:0] w_mainD;
  logic [WIDTH-1:0] w_mainQ;
  logic [WIDTH-1:0] w_skidQ;

  // Ready depends only on registered state, rst and flush, so out_ready never reaches in_ready.
  assign w_inReady  = ~rst & ~flush & (r_state != S_TWO);
  assign w_outValid = ~flush & (r_state != S_EMPTY);
  assign w_inXfer   = in_valid & w_inReady;
  assign w_outXfer  = w_outValid & out_ready;
  assign w_stall    = w_outValid & ~out_ready;

  // Decide which data register loads this cycle and from where.
  always_comb begin
    w_mainEn = 1'b0;
    w_skidEn = 1'b0;
    w_mainD  = in_data;
    case (r_state)
      S_EMPTY: begin
        w_mainEn = w_inXfer;
      end
      S_ONE: begin
        w_mainEn = w_inXfer & w_outXfer;
        w_skidEn = w_inXfer & ~w_outXfer;
      end
      S_TWO: begin
        w_mainEn = w_outXfer;
        w_mainD  = w_skidQ;
      end
      default: begin
        w_mainEn = 1'b0;
      end
    endcase
  end

  en_reg #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_mainReg (
    .clk     (clk),
    .rst     (rst),
    .i_clear (flush),
    .i_en    (w_mainEn),
    .i_d     (w_mainD),
    .o_q     (w_mainQ)
  );

  en_reg #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_skidReg (
    .clk     (clk),
    .rst     (rst),
    .i_clear (flush),
    .i_en    (w_skidEn),
    .i_d     (in_data),
    .o_q     (w_skidQ)
  );

  // Occupancy tracking; rst and flush both empty the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
    end else if (flush) begin
      r_state <= S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_inXfer) r_state <= S_ONE;
        end
        S_ONE: begin
          if (w_inXfer && !w_outXfer) begin
            r_state <= S_TWO;
          end else if (!w_inXfer && w_outXfer) begin
            r_state <= S_EMPTY;
          end
        end
        S_TWO: begin
          if (w_outXfer) r_state <= S_ONE;
        end
        default: begin
          r_state <= S_EMPTY;
        end
      endcase
    end
  end

  // Count presented-but-not-taken cycles, sticking at all-ones; flush cycles never count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stallCnt <= '0;
    end else if (w_stall && (r_stallCnt != {CNT_W{1'b1}})) begin
      r_stallCnt <= r_stallCnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign in_ready  = w_inReady;
  assign out_valid = w_outValid;
  assign out_data  = w_mainQ;
  assign count     = r_state;
  assign stall_cnt = r_stallCnt;

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Self-checking bench for pipe_reg_skid using a queue scoreboard of expected entries.
module tb_pipe_reg_skid;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  count;
  logic [15:0] stall_cnt;

  logic        s_flush;
  logic        s_inValid;
  logic        s_inReady;
  logic [31:0] s_inData;
  logic        s_outValid;
  logic        s_outReady;
  logic [31:0] s_outData;
  logic [1:0]  s_count;
  logic [1:0]  s_stallCnt;

  logic [31:0] scoreQ[$];
  int          expStall;
  int          nChecks;
  int          nFails;

  pipe_reg_skid dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .stall_cnt (stall_cnt)
  );

  pipe_reg_skid #(.WIDTH(32), .CNT_W(2)) dutSat (
    .clk       (clk),
    .rst       (rst),
    .flush     (s_flush),
    .in_valid  (s_inValid),
    .in_ready  (s_inReady),
    .in_data   (s_inData),
    .out_valid (s_outValid),
    .out_ready (s_outReady),
    .out_data  (s_outData),
    .count     (s_count),
    .stall_cnt (s_stallCnt)
  );

  always #5 clk = ~clk;

  // Advance one clock, updating the scoreboard with the transfers the current inputs imply.
  task automatic tick();
    bit mIn;
    bit mOut;
    mIn  = !rst && !flush && in_valid && (scoreQ.size() < 2);
    mOut = !rst && !flush && (scoreQ.size() > 0) && out_ready;
    if (rst) begin
      scoreQ.delete();
      expStall = 0;
    end else if (flush) begin
      scoreQ.delete();
    end else begin
      if ((scoreQ.size() > 0) && !out_ready && (expStall < 65535)) expStall++;
      if (mOut) void'(scoreQ.pop_front());
      if (mIn) scoreQ.push_back(in_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b0;
    tick();
    tick();
    nChecks++; if (out_valid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid); end
    nChecks++; if (count !== 2'd0) begin nFails++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    nChecks++; if (out_data !== 32'h0) begin nFails++; $display("[TB] FAIL reset_out_data: got %h expected 0", out_data); end
    nChecks++; if (stall_cnt !== 16'd0) begin nFails++; $display("[TB] FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
    nChecks++; if (in_ready !== 1'b0) begin nFails++; $display("[TB] FAIL reset_in_ready_low: got %0b expected 0", in_ready); end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    nChecks++; if (in_ready !== 1'b1) begin nFails++; $display("[TB] FAIL reset_in_ready_release: got %0b expected 1", in_ready); end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data = 32'(i);
      tick();
      nChecks++; if (scoreQ.size() != 1 || out_data !== scoreQ[0] || out_data !== 32'(i)) begin nFails++; $display("[TB] FAIL stream_data_%0d: got %h expected %h", i, out_data, 32'(i)); end
      nChecks++; if (count !== 2'd1 || out_valid !== 1'b1) begin nFails++; $display("[TB] FAIL stream_count_%0d: got count %0d valid %0b expected 1 1", i, count, out_valid); end
      nChecks++; if (in_ready !== 1'b1) begin nFails++; $display("[TB] FAIL stream_in_ready_%0d: got %0b expected 1", i, in_ready); end
    end
    in_valid = 1'b0;
    tick();
    nChecks++; if (count !== 2'd0 || out_valid !== 1'b0) begin nFails++; $display("[TB] FAIL stream_drain: got count %0d valid %0b expected 0 0", count, out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    tick();
    in_data   = 32'hB;
    tick();
    in_valid  = 1'b0;
    nChecks++; if (count !== 2'd2) begin nFails++; $display("[TB] FAIL bp_count_two: got %0d expected 2", count); end
    nChecks++; if (in_ready !== 1'b0) begin nFails++; $display("[TB] FAIL bp_in_ready: got %0b expected 0", in_ready); end
    nChecks++; if (out_data !== 32'hA) begin nFails++; $display("[TB] FAIL bp_head: got %h expected a", out_data); end
    for (int i = 0; i < 5; i++) tick();
    nChecks++; if (stall_cnt !== 16'(expStall) || stall_cnt !== 16'd6) begin nFails++; $display("[TB] FAIL bp_stall_cnt: got %0d expected 6", stall_cnt); end
    nChecks++; if (out_data !== 32'hA) begin nFails++; $display("[TB] FAIL bp_head_stable: got %h expected a", out_data); end
    out_ready = 1'b1;
    #1;
    nChecks++; if (out_valid !== 1'b1 || out_data !== scoreQ[0]) begin nFails++; $display("[TB] FAIL bp_pop_first: got %h expected %h", out_data, scoreQ[0]); end
    tick();
    nChecks++; if (out_data !== scoreQ[0] || out_data !== 32'hB || count !== 2'd1) begin nFails++; $display("[TB] FAIL bp_pop_second: got %h count %0d expected b count 1", out_data, count); end
    tick();
    nChecks++; if (count !== 2'd0 || out_valid !== 1'b0) begin nFails++; $display("[TB] FAIL bp_empty: got count %0d valid %0b expected 0 0", count, out_valid); end
    nChecks++; if (stall_cnt !== 16'(expStall)) begin nFails++; $display("[TB] FAIL bp_stall_hold: got %0d expected %0d", stall_cnt, expStall); end
  endtask

  task automatic test_simultaneous();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h5;
    tick();
    nChecks++; if (out_data !== 32'h5 || count !== 2'd1) begin nFails++; $display("[TB] FAIL sim_setup: got %h count %0d expected 5 count 1", out_data, count); end
    in_data   = 32'h6;
    out_ready = 1'b1;
    tick();
    nChecks++; if (out_data !== 32'h6 || out_data !== scoreQ[0] || count !== 2'd1) begin nFails++; $display("[TB] FAIL sim_swap: got %h count %0d expected 6 count 1", out_data, count); end
    in_valid = 1'b0;
    tick();
    nChecks++; if (count !== 2'd0) begin nFails++; $display("[TB] FAIL sim_drain: got %0d expected 0", count); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    tick();
    in_data   = 32'hB;
    tick();
    nChecks++; if (count !== 2'd2) begin nFails++; $display("[TB] FAIL flush_setup: got %0d expected 2", count); end
    flush   = 1'b1;
    in_data = 32'hC;
    #1;
    nChecks++; if (out_valid !== 1'b0) begin nFails++; $display("[TB] FAIL flush_out_valid: got %0b expected 0", out_valid); end
    nChecks++; if (in_ready !== 1'b0) begin nFails++; $display("[TB] FAIL flush_in_ready: got %0b expected 0", in_ready); end
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    nChecks++; if (count !== 2'd0) begin nFails++; $display("[TB] FAIL flush_count: got %0d expected 0", count); end
    nChecks++; if (out_data !== 32'h0) begin nFails++; $display("[TB] FAIL flush_out_data: got %h expected 0", out_data); end
    nChecks++; if (stall_cnt !== 16'(expStall) || stall_cnt !== 16'd7) begin nFails++; $display("[TB] FAIL flush_stall_hold: got %0d expected 7", stall_cnt); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      nChecks++; if (out_valid !== 1'b0 || scoreQ.size() != 0) begin nFails++; $display("[TB] FAIL flush_no_emit_%0d: got valid %0b data %h expected valid 0", i, out_valid, out_data); end
    end
  endtask

  task automatic test_saturation();
    logic [1:0] expSat;
    s_outReady = 1'b0;
    s_inValid  = 1'b1;
    s_inData   = 32'h77;
    tick();
    s_inValid  = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      expSat = (i >= 3) ? 2'd3 : 2'(i);
      nChecks++; if (s_stallCnt !== expSat) begin nFails++; $display("[TB] FAIL sat_cycle_%0d: got %0d expected %0d", i, s_stallCnt, expSat); end
    end
    nChecks++; if (s_outData !== 32'h77 || s_outValid !== 1'b1) begin nFails++; $display("[TB] FAIL sat_head: got %h valid %0b expected 77 valid 1", s_outData, s_outValid); end
  endtask

  initial begin
    nChecks = 0; nFails = 0; expStall = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    s_flush = 1'b0; s_inValid = 1'b0; s_inData = '0; s_outReady = 1'b0;
    #1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_simultaneous();
    test_flush();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/pipe_reg_skid.md
Name: pipe_reg_skid

Overview:
- Parametrised pipeline register with a valid/ready handshake, a one-entry skid buffer, and a synchronous flush.
- It replaces fixed-width enabled registers between CPU datapath stages, e.g. fetch->decode and execute->writeback, when stages gain independent stall control.
- Sustains 1 transfer/cycle with no combinational path from out_ready to in_ready.
- Includes a saturating back-pressure cycle counter for performance debug.

Parameters:
- WIDTH, 32, data width in bits (>=1).
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into data registers on rst and flush.
- CNT_W, 16, width of the stall_cnt counter (>=2).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  sync kill of all held entries (hazard/branch unit).
- in_valid  input  1  upstream data valid.
- in_ready  output  1  block can accept in_data this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  out_data holds a valid entry.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  WIDTH  head entry (main register).
- count  output  2  occupancy, 0..2.
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0; saturates at all-ones.

Behaviour:
- Handshakes: an input transfer happens iff in_valid & in_ready. An output transfer happens iff out_valid & out_ready.
- State register has three values:
  - EMPTY (count=0).
  - ONE (main valid, count=1).
  - TWO (main and skid valid, count=2).
- in_ready = ~rst & ~flush & (state!=TWO). It depends only on registered state, rst and flush, never on out_ready.
- out_valid = ~flush & (state!=EMPTY). out_data = main register at all times.
- Transitions (priority rst > flush > normal):
  - rst: state<=EMPTY; main, skid<=RESET_VALUE; stall_cnt<=0.
  - flush (no rst): state<=EMPTY; main, skid<=RESET_VALUE. Input is not accepted and output is not presented that cycle. stall_cnt holds.
  - EMPTY: on input transfer, main<=in_data and state<=ONE; otherwise hold.
  - ONE:
    - input and output transfer: main<=in_data, stay ONE.
    - input only: skid<=in_data, state<=TWO.
    - output only: state<=EMPTY.
    - neither: hold.
  - TWO: on output transfer, main<=skid and state<=ONE; otherwise hold. No input transfer is possible because in_ready=0.
- Latency: data accepted at edge N appears on out_data/out_valid after edge N (1 cycle). Skid entry reaches out_data 1 cycle after the head drains.
- Ordering: strict FIFO. No entry is dropped or duplicated except by flush/rst.
- Data registers not written in a cycle hold their value; there are no other enables.
- stall_cnt: increments by 1 each non-rst, non-flush cycle where out_valid=1 & out_ready=0. It holds at 2^CNT_W-1 once reached, with no wrap.
- Reset mid-operation: all held entries are discarded. in_ready=0 while rst is high, and =1 on the first cycle after rst deasserts.
- Flush in the same cycle as an in_valid: that input is dropped. Upstream sees in_ready=0, so it is not a completed handshake.
- While TWO and out_ready=0: out_data and skid are stable indefinitely.

Decomposition:
- Shared package pipe_pkg:
  - typedef enum logic[1:0] skid_state_t {S_EMPTY=2'd0, S_ONE=2'd1, S_TWO=2'd2}.
  - Localparam for the count width (2).
- One natural sub-module: en_reg, a parametrised (WIDTH, RESET_VALUE) register with sync active-high rst, a clear input and an enable. It is instantiated twice, for main and skid.
- State machine and stall counter stay in pipe_reg_skid.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1, in_data=32'hDEADBEEF. Require out_valid=0, count=0, out_data=0, stall_cnt=0, in_ready=0. After release, in_ready=1.
- Streaming: out_ready=1, push 0x1,0x2,0x3 on consecutive cycles. Require out_data 0x1,0x2,0x3 on the following consecutive cycles, count stays 1, in_ready stays 1.
- Back-pressure/skid:
  - out_ready=0, push 0xA then 0xB. Require count=2, in_ready=0, out_data=0xA.
  - Hold 5 cycles: stall_cnt=6 (stall counting starts the cycle 0xA is presented).
  - Raise out_ready: require 0xA then 0xB out, count ->1 ->0.
- Simultaneous transfer in ONE: main=0x5 valid; in the same cycle in_valid=1 with 0x6 and out_ready=1. Require next cycle out_data=0x6, count=1.
- Flush: state TWO (0xA, 0xB), assert flush with in_valid=1 and in_data=0xC.
  - During the flush cycle: out_valid=0, in_ready=0.
  - Next cycle: count=0, out_data=RESET_VALUE, and 0xC is never emitted.
- Saturation: CNT_W=2, out_valid=1, out_ready=0 for 6 cycles. Require stall_cnt sequence 1,2,3,3,3,3.
